// File: rtl/wb_timer_ctrl_8051.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : wb_timer_ctrl_8051                                              |
// | Purpose : TCON/TMOD control-and-status block for the FP51 Timer0/Timer1   |
// |           pair. Holds the TMOD mode bits and TCON run bits, captures the  |
// |           timer overflow pulses into TF0/TF1, synchronizes and            |
// |           edge/level-detects the INT0/INT1 pins into IE0/IE1, and         |
// |           presents TF/IE as interrupt requests.                           |
// | Ports   : clk, reset_n (async, active-low)                                |
// |           stb_i/we_i/adr_wr_i/adr_rd_i/dat_i/dat_o/ack_o : Wishbone SFR   |
// |           timer_trigger[1:0] : overflow pulses from the timers            |
// |           int_ack_timer/int_ack_ext[1:0] : vector-taken acknowledges      |
// |           INTx_pin_n[1:0]    : raw async pins, active-low                 |
// |           INTx_sync[1:0]     : synchronized pin level, active-high        |
// |           TMOD_GATE/C_T/M1/M0, TCON_TR : per-timer control outputs        |
// |           irq_timer = TF, irq_ext = IE                                    |
// | Revision: 1.0 - initial release                                           |
// +--------------------------------------------------------------------------+
module wb_timer_ctrl_8051 #(
  parameter logic [7:0] REG_ADDR_TCON = 8'h88,
  parameter logic [7:0] REG_ADDR_TMOD = 8'h89,
  parameter int         SYNC_STAGES   = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       stb_i,
  input  logic       we_i,
  input  logic [7:0] adr_wr_i,
  input  logic [7:0] adr_rd_i,
  input  logic [7:0] dat_i,
  output logic [7:0] dat_o,
  output logic       ack_o,
  input  logic [1:0] timer_trigger,
  input  logic [1:0] int_ack_timer,
  input  logic [1:0] int_ack_ext,
  input  logic [1:0] INTx_pin_n,
  output logic [1:0] INTx_sync,
  output logic [1:0] TMOD_GATE,
  output logic [1:0] TMOD_C_T,
  output logic [1:0] TMOD_M1,
  output logic [1:0] TMOD_M0,
  output logic [1:0] TCON_TR,
  output logic [1:0] irq_timer,
  output logic [1:0] irq_ext
);

  // Register state
  logic [7:0] tmod_q, tmod_d;
  logic [1:0] tf_q,   tf_d;
  logic [1:0] tr_q,   tr_d;
  logic [1:0] ie_q,   ie_d;
  logic [1:0] it_q,   it_d;

  // The synchronizer chains carry the inverted (active-high) pin level, so
  // the last stage is the INTx_sync output directly. Reset loads all stages
  // and the edge history with 1, so no rising edge is seen on reset release.
  logic [1:0][SYNC_STAGES-1:0] sync_q, sync_d;
  logic [1:0]                  hist_q, hist_d;

  logic       wr_tcon;
  logic       wr_tmod;
  logic [1:0] w_tf_wr;
  logic [1:0] w_ie_wr;
  logic [1:0] w_rise;

  assign wr_tcon = stb_i & we_i & (adr_wr_i == REG_ADDR_TCON);
  assign wr_tmod = stb_i & we_i & (adr_wr_i == REG_ADDR_TMOD);

  // TCON = {TF1,TR1,TF0,TR0,IE1,IT1,IE0,IT0}
  assign w_tf_wr = {dat_i[7], dat_i[5]};
  assign w_ie_wr = {dat_i[3], dat_i[1]};

  for (genvar n = 0; n < 2; n++) begin : g_int
    assign INTx_sync[n] = sync_q[n][SYNC_STAGES-1];
    assign w_rise[n]    = INTx_sync[n] & ~hist_q[n];
  end

  always_comb begin
    tmod_d = tmod_q;
    tf_d   = tf_q;
    tr_d   = tr_q;
    ie_d   = ie_q;
    it_d   = it_q;
    hist_d = INTx_sync;
    sync_d = sync_q;

    for (int n = 0; n < 2; n++) begin
      sync_d[n] = {sync_q[n][SYNC_STAGES-2:0], ~INTx_pin_n[n]};
    end

    if (wr_tmod) begin
      tmod_d = dat_i;
    end

    if (wr_tcon) begin
      tr_d = {dat_i[6], dat_i[4]};
      it_d = {dat_i[2], dat_i[0]};
    end

    for (int n = 0; n < 2; n++) begin
      // TF: overflow set beats software write, which beats ack clear.
      if (wr_tcon) begin
        tf_d[n] = w_tf_wr[n];
      end else if (int_ack_timer[n]) begin
        tf_d[n] = 1'b0;
      end
      if (timer_trigger[n]) begin
        tf_d[n] = 1'b1;
      end

      // IE: mode is taken from the current IT bit, so an edge seen while
      // still in level mode never latches after switching to edge mode.
      if (it_q[n]) begin
        if (wr_tcon) begin
          ie_d[n] = w_ie_wr[n];
        end else if (int_ack_ext[n]) begin
          ie_d[n] = 1'b0;
        end
        if (w_rise[n]) begin
          ie_d[n] = 1'b1;
        end
      end else begin
        ie_d[n] = INTx_sync[n];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmod_q <= 8'h00;
      tf_q   <= 2'b00;
      tr_q   <= 2'b00;
      ie_q   <= 2'b00;
      it_q   <= 2'b00;
      sync_q <= '1;
      hist_q <= 2'b11;
    end else begin
      tmod_q <= tmod_d;
      tf_q   <= tf_d;
      tr_q   <= tr_d;
      ie_q   <= ie_d;
      it_q   <= it_d;
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end

  // Bus side
  assign ack_o = stb_i;

  always_comb begin
    dat_o = 8'h00;
    if (adr_rd_i == REG_ADDR_TCON) begin
      dat_o = {tf_q[1], tr_q[1], tf_q[0], tr_q[0], ie_q[1], it_q[1], ie_q[0], it_q[0]};
    end else if (adr_rd_i == REG_ADDR_TMOD) begin
      dat_o = tmod_q;
    end
  end

  // TMOD = {GATE1,C/T1,M1_1,M0_1,GATE0,C/T0,M1_0,M0_0}
  assign TMOD_GATE = {tmod_q[7], tmod_q[3]};
  assign TMOD_C_T  = {tmod_q[6], tmod_q[2]};
  assign TMOD_M1   = {tmod_q[5], tmod_q[1]};
  assign TMOD_M0   = {tmod_q[4], tmod_q[0]};
  assign TCON_TR   = tr_q;
  assign irq_timer = tf_q;
  assign irq_ext   = ie_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_timer_ctrl_8051.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_wb_timer_ctrl_8051                                           |
// | Purpose : Directed self-checking bench for wb_timer_ctrl_8051            |
// |           (register readback, TF priority, edge/level INTx, async reset) |
// | Revision: 1.0 - initial release                                           |
// +--------------------------------------------------------------------------+
module tb_wb_timer_ctrl_8051;

  localparam logic [7:0] ADDR_TCON = 8'h88;
  localparam logic [7:0] ADDR_TMOD = 8'h89;
  localparam int         SYNC      = 2;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       stb_i = 1'b0;
  logic       we_i = 1'b0;
  logic [7:0] adr_wr_i = 8'h00;
  logic [7:0] adr_rd_i = ADDR_TCON;
  logic [7:0] dat_i = 8'h00;
  logic [7:0] dat_o;
  logic       ack_o;
  logic [1:0] timer_trigger = 2'b00;
  logic [1:0] int_ack_timer = 2'b00;
  logic [1:0] int_ack_ext = 2'b00;
  logic [1:0] INTx_pin_n = 2'b11;
  logic [1:0] INTx_sync;
  logic [1:0] TMOD_GATE, TMOD_C_T, TMOD_M1, TMOD_M0, TCON_TR;
  logic [1:0] irq_timer, irq_ext;

  int n_checks = 0;
  int n_fail   = 0;

  wb_timer_ctrl_8051 #(
    .REG_ADDR_TCON(ADDR_TCON),
    .REG_ADDR_TMOD(ADDR_TMOD),
    .SYNC_STAGES  (SYNC)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .stb_i        (stb_i),
    .we_i         (we_i),
    .adr_wr_i     (adr_wr_i),
    .adr_rd_i     (adr_rd_i),
    .dat_i        (dat_i),
    .dat_o        (dat_o),
    .ack_o        (ack_o),
    .timer_trigger(timer_trigger),
    .int_ack_timer(int_ack_timer),
    .int_ack_ext  (int_ack_ext),
    .INTx_pin_n   (INTx_pin_n),
    .INTx_sync    (INTx_sync),
    .TMOD_GATE    (TMOD_GATE),
    .TMOD_C_T     (TMOD_C_T),
    .TMOD_M1      (TMOD_M1),
    .TMOD_M0      (TMOD_M0),
    .TCON_TR      (TCON_TR),
    .irq_timer    (irq_timer),
    .irq_ext      (irq_ext)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  // Advance n clock edges, leaving time 1 unit after the last edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    stb_i = 1'b1; we_i = 1'b1; adr_wr_i = a; dat_i = d;
    tick(1);
    stb_i = 1'b0; we_i = 1'b0;
  endtask

  task automatic rd_check(input string tag, input logic [7:0] a, input logic [7:0] exp);
    adr_rd_i = a;
    #1;
    check(tag, dat_o, exp);
  endtask

  initial begin
    // ---- Reset state (pins idle high) ----
    #2 reset_n = 1'b0;
    #10;
    check("rst_sync",   {6'd0, INTx_sync}, 8'h03);
    check("rst_irq_t",  {6'd0, irq_timer}, 8'h00);
    check("rst_irq_e",  {6'd0, irq_ext},   8'h00);
    check("rst_tr",     {6'd0, TCON_TR},   8'h00);
    rd_check("rst_tcon", ADDR_TCON, 8'h00);
    rd_check("rst_tmod", ADDR_TMOD, 8'h00);
    #9 reset_n = 1'b1;
    tick(1);
    check("sync_hold",  {6'd0, INTx_sync}, 8'h03);
    tick(SYNC - 1);
    check("sync_idle",  {6'd0, INTx_sync}, 8'h00);
    tick(2);
    check("ie_settled", {6'd0, irq_ext},   8'h00);

    // ---- TMOD/TCON readback and decode ----
    stb_i = 1'b1; #1;
    check("ack", {7'd0, ack_o}, 8'h01);
    stb_i = 1'b0; #1;
    check("ack_idle", {7'd0, ack_o}, 8'h00);
    wr(ADDR_TMOD, 8'hA5);
    rd_check("tmod_rd", ADDR_TMOD, 8'hA5);
    wr(ADDR_TCON, 8'h50);
    rd_check("tcon_rd", ADDR_TCON, 8'h50);
    rd_check("unmapped", 8'h8A, 8'h00);
    check("gate", {6'd0, TMOD_GATE}, 8'h02);
    check("c_t",  {6'd0, TMOD_C_T},  8'h01);
    check("m1",   {6'd0, TMOD_M1},   8'h02);
    check("m0",   {6'd0, TMOD_M0},   8'h01);
    check("tr",   {6'd0, TCON_TR},   8'h03);

    // ---- TF priority ----
    timer_trigger = 2'b01; int_ack_timer = 2'b01;
    tick(1);
    timer_trigger = 2'b00; int_ack_timer = 2'b00;
    check("tf0_set_wins", {6'd0, irq_timer}, 8'h01);
    rd_check("tcon_tf0", ADDR_TCON, 8'h70);
    int_ack_timer = 2'b01;
    tick(1);
    int_ack_timer = 2'b00;
    check("tf0_ack", {6'd0, irq_timer}, 8'h00);
    timer_trigger = 2'b10;
    wr(ADDR_TCON, 8'h50);
    timer_trigger = 2'b00;
    check("tf1_trig_vs_wr0", {6'd0, irq_timer}, 8'h02);
    rd_check("tcon_tf1", ADDR_TCON, 8'hD0);
    wr(ADDR_TCON, 8'h50);
    check("tf1_sw_clear", {6'd0, irq_timer}, 8'h00);
    int_ack_timer = 2'b01;
    wr(ADDR_TCON, 8'h70);
    int_ack_timer = 2'b00;
    check("tf0_wr_vs_ack", {6'd0, irq_timer}, 8'h01);
    wr(ADDR_TCON, 8'h50);

    // ---- Edge mode on INT1 ----
    wr(ADDR_TCON, 8'h54);
    INTx_pin_n = 2'b01;
    tick(SYNC);
    check("e_sync", {6'd0, INTx_sync}, 8'h02);
    check("e_not_yet", {6'd0, irq_ext}, 8'h00);
    tick(1);
    check("e_set", {6'd0, irq_ext}, 8'h02);
    rd_check("tcon_ie1", ADDR_TCON, 8'h5C);
    tick(2);
    INTx_pin_n = 2'b11;
    check("e_held", {6'd0, irq_ext}, 8'h02);
    int_ack_ext = 2'b10;
    tick(1);
    int_ack_ext = 2'b00;
    check("e_ack", {6'd0, irq_ext}, 8'h00);
    tick(4);
    check("e_no_reset", {6'd0, irq_ext}, 8'h00);
    // Pin held low: one set, no re-set after the ack.
    INTx_pin_n = 2'b01;
    tick(SYNC + 1);
    check("e_low_set", {6'd0, irq_ext}, 8'h02);
    int_ack_ext = 2'b10;
    tick(1);
    int_ack_ext = 2'b00;
    tick(5);
    check("e_low_once", {6'd0, irq_ext}, 8'h00);
    INTx_pin_n = 2'b11;
    tick(4);

    // ---- Level mode on INT0 ----
    INTx_pin_n = 2'b10;
    tick(SYNC + 1);
    check("l_track", {6'd0, irq_ext}, 8'h01);
    tick(2);
    wr(ADDR_TCON, 8'h54);
    check("l_wr_ignored", {6'd0, irq_ext}, 8'h01);
    int_ack_ext = 2'b01;
    tick(1);
    int_ack_ext = 2'b00;
    check("l_ack_ignored", {6'd0, irq_ext}, 8'h01);
    tick(3);
    INTx_pin_n = 2'b11;
    tick(SYNC);
    check("l_release_lag", {6'd0, irq_ext}, 8'h01);
    tick(1);
    check("l_release", {6'd0, irq_ext}, 8'h00);

    // ---- Asynchronous reset mid-operation ----
    timer_trigger = 2'b10;
    tick(1);
    timer_trigger = 2'b00;
    check("pre_rst_tf1", {6'd0, irq_timer}, 8'h02);
    check("pre_rst_tr",  {6'd0, TCON_TR},   8'h03);
    #2 reset_n = 1'b0;
    #1;
    check("arst_irq_t", {6'd0, irq_timer}, 8'h00);
    check("arst_tr",    {6'd0, TCON_TR},   8'h00);
    check("arst_gate",  {6'd0, TMOD_GATE}, 8'h00);
    check("arst_m1",    {6'd0, TMOD_M1},   8'h00);
    check("arst_irq_e", {6'd0, irq_ext},   8'h00);
    check("arst_sync",  {6'd0, INTx_sync}, 8'h03);
    rd_check("arst_tcon", ADDR_TCON, 8'h00);
    #10 reset_n = 1'b1;
    tick(SYNC + 2);
    check("post_rst_ie", {6'd0, irq_ext}, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
